// File: rtl/verifier_chi_dot_stream_pkg.sv
// Shared field definitions for the chi dot-product stream.
// The field is GF(q) with q = 2^61 - 1, a Mersenne prime, so a product
// reduces with two folds and one conditional subtract.
// Contents: F_NBITS, F_Q, fe_t, and the helpers fq_add and fq_mul.
package verifier_chi_dot_stream_pkg;

    localparam int            F_NBITS = 61;
    localparam logic [60:0]   F_Q     = 61'h1FFF_FFFF_FFFF_FFFF;

    typedef logic [F_NBITS-1:0] fe_t;

    // Modular add; both operands are already below q
    function automatic fe_t fq_add(input fe_t a, input fe_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) begin
            s = s - {1'b0, F_Q};
        end else begin
            s = s;
        end
        return s[F_NBITS-1:0];
    endfunction

    // Modular multiply. Because 2^61 == 1 mod q, the high half of the product
    // folds onto the low half. After the second fold the value is at most q,
    // so one conditional subtract finishes the reduction.
    function automatic fe_t fq_mul(input fe_t a, input fe_t b);
        logic [2*F_NBITS-1:0] p;
        logic [F_NBITS:0]     s;
        p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        s = {1'b0, p[F_NBITS-1:0]} + {1'b0, p[2*F_NBITS-1:F_NBITS]};
        s = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
        if (s >= {1'b0, F_Q}) begin
            s = s - {1'b0, F_Q};
        end else begin
            s = s;
        end
        return s[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/field_arith.sv
// Field arithmetic units with an en/ready handshake.
// field_multiplier: a pulse on en computes a*b mod q. The registered result
//                   appears with ready=1 one cycle later and then holds.
// field_adder     : a pulse on en computes a+b mod q, with the same timing.
// Ports: clk, rstb (synchronous, active high), en, a, b -> res, ready.
module field_multiplier
    import verifier_chi_dot_stream_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  fe_t  a,
    input  fe_t  b,
    output fe_t  res,
    output logic ready
);
    fe_t  res_d, res_q;
    logic ready_d, ready_q;

    // Capture the reduced product on en; otherwise hold the last result
    always_comb begin
        res_d   = res_q;
        ready_d = 1'b0;
        if (en) begin
            res_d   = fq_mul(a, b);
            ready_d = 1'b1;
        end else begin
            res_d   = res_q;
        end
    end

    // Result and ready registers
    always_ff @(posedge clk) begin
        if (rstb) begin
            res_q   <= {F_NBITS{1'b0}};
            ready_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            ready_q <= ready_d;
        end
    end

    assign res   = res_q;
    assign ready = ready_q;
endmodule

module field_adder
    import verifier_chi_dot_stream_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  fe_t  a,
    input  fe_t  b,
    output fe_t  res,
    output logic ready
);
    fe_t  res_d, res_q;
    logic ready_d, ready_q;

    // Capture the reduced sum on en; otherwise hold the last result
    always_comb begin
        res_d   = res_q;
        ready_d = 1'b0;
        if (en) begin
            res_d   = fq_add(a, b);
            ready_d = 1'b1;
        end else begin
            res_d   = res_q;
        end
    end

    // Result and ready registers
    always_ff @(posedge clk) begin
        if (rstb) begin
            res_q   <= {F_NBITS{1'b0}};
            ready_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            ready_q <= ready_d;
        end
    end

    assign res   = res_q;
    assign ready = ready_q;
endmodule

// File: rtl/verifier_chi_idx_mux.sv
// Registered nValues:1 select of the chi vector by element index.
// The select is registered so the wide mux stays off the multiplier input path.
// Ports: clk, rstb, load (capture enable), chi_in (whole vector), idx -> chi_out.
module verifier_chi_idx_mux
    import verifier_chi_dot_stream_pkg::*;
#(
    parameter int nValBits = 8
) (
    input  logic                                     clk,
    input  logic                                     rstb,
    input  logic                                     load,
    input  logic [(1<<nValBits)-1:0][F_NBITS-1:0]    chi_in,
    input  logic [nValBits-1:0]                      idx,
    output fe_t                                      chi_out
);
    fe_t chi_d, chi_q;

    // Select chi[idx] on load; otherwise hold the captured element
    always_comb begin
        chi_d = chi_q;
        if (load) begin
            chi_d = chi_in[idx];
        end else begin
            chi_d = chi_q;
        end
    end

    // Selected-element register
    always_ff @(posedge clk) begin
        if (rstb) begin
            chi_q <= {F_NBITS{1'b0}};
        end else begin
            chi_q <= chi_d;
        end
    end

    assign chi_out = chi_q;
endmodule

// File: rtl/verifier_chi_dot_stream.sv
// Serial dot product sum_i chi[i]*v[i] mod q, where v[i] is streamed one
// beat per MAC.
// Ports: clk; rstb (synchronous, active high); en (a rising edge starts a pass);
//        chi_in (whole chi vector, held stable during a pass);
//        val_in/val_valid/val_ready (operand stream; index ascends from 0);
//        dot_out (result, held until the next start); ready (idle, no start this cycle).
module verifier_chi_dot_stream
    import verifier_chi_dot_stream_pkg::*;
#(
    parameter  int nValBits = 8,
    localparam int nValues  = 1 << nValBits
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic                              en,
    input  logic [nValues-1:0][F_NBITS-1:0]   chi_in,
    input  fe_t                               val_in,
    input  logic                              val_valid,
    output logic                              val_ready,
    output fe_t                               dot_out,
    output logic                              ready
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAITV  = 3'd1,
        ST_MUL_ST = 3'd2,
        ST_MUL    = 3'd3,
        ST_ADD_ST = 3'd4,
        ST_ADD    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [nValBits-1:0] IDX_LAST = nValBits'(nValues - 1);
    localparam logic [nValBits-1:0] IDX_ONE  = nValBits'(1);

    state_t               state_d, state_q;
    logic                 en_dly_d, en_dly_q;
    logic [nValBits-1:0]  idx_d, idx_q;
    fe_t                  acc_d, acc_q;
    fe_t                  op_d, op_q;
    fe_t                  dot_d, dot_q;

    logic start_s, load_s, mul_en_s, add_en_s, mul_rdy_s, add_rdy_s;
    fe_t  chi_sel_s, prod_s, sum_s;

    assign start_s = en & ~en_dly_q;
    assign load_s  = (state_q == ST_WAITV) & val_valid;

    verifier_chi_idx_mux #(.nValBits(nValBits)) u_chi_mux (
        .clk     (clk),
        .rstb    (rstb),
        .load    (load_s),
        .chi_in  (chi_in),
        .idx     (idx_q),
        .chi_out (chi_sel_s)
    );

    field_multiplier u_mul (
        .clk   (clk),
        .rstb  (rstb),
        .en    (mul_en_s),
        .a     (chi_sel_s),
        .b     (op_q),
        .res   (prod_s),
        .ready (mul_rdy_s)
    );

    field_adder u_add (
        .clk   (clk),
        .rstb  (rstb),
        .en    (add_en_s),
        .a     (acc_q),
        .b     (prod_s),
        .res   (sum_s),
        .ready (add_rdy_s)
    );

    // Next-state and datapath control for one MAC per accepted beat
    always_comb begin
        state_d  = state_q;
        en_dly_d = en;
        idx_d    = idx_q;
        acc_d    = acc_q;
        op_d     = op_q;
        dot_d    = dot_q;
        mul_en_s = 1'b0;
        add_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    acc_d   = {F_NBITS{1'b0}};
                    idx_d   = {nValBits{1'b0}};
                    state_d = ST_WAITV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAITV: begin
                if (val_valid) begin
                    op_d    = val_in;
                    state_d = ST_MUL_ST;
                end else begin
                    state_d = ST_WAITV;
                end
            end
            ST_MUL_ST: begin
                mul_en_s = 1'b1;
                state_d  = ST_MUL;
            end
            ST_MUL: begin
                if (mul_rdy_s) begin
                    state_d = ST_ADD_ST;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_ADD_ST: begin
                add_en_s = 1'b1;
                state_d  = ST_ADD;
            end
            ST_ADD: begin
                if (add_rdy_s) begin
                    acc_d = sum_s;
                    // The terminal test comes before the increment, so idx never wraps
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_WAITV;
                    end
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                dot_d   = acc_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; en_dly resets high so a held en cannot start a pass
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q  <= ST_IDLE;
            en_dly_q <= 1'b1;
            idx_q    <= {nValBits{1'b0}};
            acc_q    <= {F_NBITS{1'b0}};
            op_q     <= {F_NBITS{1'b0}};
            dot_q    <= {F_NBITS{1'b0}};
        end else begin
            state_q  <= state_d;
            en_dly_q <= en_dly_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            dot_q    <= dot_d;
        end
    end

    assign val_ready = (state_q == ST_WAITV);
    assign ready     = (state_q == ST_IDLE) & ~start_s;
    assign dot_out   = dot_q;
endmodule

// File: tb/tb_verifier_chi_dot_stream.sv
// Self-checking bench: a small instance (nValBits=2) for directed, gap and
// reset scenarios, and a full-size instance (nValBits=8) for back-to-back
// random passes. The expected values come from a modular-arithmetic model.
module tb_verifier_chi_dot_stream;
    import verifier_chi_dot_stream_pkg::*;

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    logic en2, val_valid2, val_ready2, ready2;
    fe_t  val_in2, dot2;
    logic [3:0][F_NBITS-1:0] chi2;

    logic en8, val_valid8, val_ready8, ready8;
    fe_t  val_in8, dot8;
    logic [255:0][F_NBITS-1:0] chi8;

    int checks = 0;
    int errors = 0;

    fe_t chi_m [256];
    fe_t v_m   [256];

    int beats2, rises2;
    bit tmo2, vr_err2, restart_err2;

    verifier_chi_dot_stream #(.nValBits(2)) dut2 (
        .clk(clk), .rstb(rstb), .en(en2), .chi_in(chi2), .val_in(val_in2),
        .val_valid(val_valid2), .val_ready(val_ready2), .dot_out(dot2), .ready(ready2)
    );

    verifier_chi_dot_stream #(.nValBits(8)) dut8 (
        .clk(clk), .rstb(rstb), .en(en8), .chi_in(chi8), .val_in(val_in8),
        .val_valid(val_valid8), .val_ready(val_ready8), .dot_out(dot8), .ready(ready8)
    );

    // Reference: sum of chi[i]*v[i] mod q using plain wide arithmetic
    function automatic fe_t model_dot(input int n);
        logic [127:0] acc, qq, p;
        qq  = {67'd0, F_Q};
        acc = 128'd0;
        for (int i = 0; i < n; i++) begin
            p   = ({67'd0, chi_m[i]} * {67'd0, v_m[i]}) % qq;
            acc = (acc + p) % qq;
        end
        return acc[F_NBITS-1:0];
    endfunction

    function automatic fe_t rand_fe();
        logic [63:0] r;
        fe_t         f;
        r = {$urandom, $urandom};
        f = r[60:0];
        case ($urandom_range(9))
            0:       return F_Q - 61'd1;
            1:       return 61'd0;
            default: return (f == F_Q) ? 61'd0 : f;
        endcase
    endfunction

    // One pass on the small instance using chi_m/v_m[0..3]. val_valid is randomised.
    task automatic pass2(input int gap_pct, input bit toggle_en);
        int cyc;
        bit hs, prev_rdy;
        beats2 = 0; rises2 = 0; tmo2 = 0; vr_err2 = 0; restart_err2 = 0;
        for (int i = 0; i < 4; i++) chi2[i] = chi_m[i];
        @(negedge clk);
        en2 = 1'b1;
        prev_rdy = 1'b0;
        cyc = 0;
        while (1) begin
            val_valid2 = ($urandom_range(99) >= gap_pct);
            val_in2    = v_m[beats2 % 4];
            hs = val_valid2 && val_ready2;
            @(negedge clk);
            cyc++;
            if (toggle_en && cyc == 3) en2 = 1'b0;
            if (toggle_en && cyc == 4) en2 = 1'b1;
            if (hs) begin
                beats2++;
                if (val_ready2) vr_err2 = 1'b1;
            end
            if (ready2 && !prev_rdy) rises2++;
            prev_rdy = ready2;
            if (ready2) break;
            if (cyc > 2000) begin tmo2 = 1'b1; break; end
        end
        // Hold en high while idle: this must not start a new pass
        val_valid2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ready2 && !prev_rdy) rises2++;
            if (!ready2 || val_ready2) restart_err2 = 1'b1;
            prev_rdy = ready2;
        end
        en2 = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready2: got %0b expected 1", ready2); end
        checks++; if (dot2 !== 61'd0) begin errors++; $display("FAIL reset_dot2: got %0d expected 0", dot2); end
        checks++; if (val_ready2 !== 1'b0) begin errors++; $display("FAIL reset_val_ready2: got %0b expected 0", val_ready2); end
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready8: got %0b expected 1", ready8); end
        checks++; if (dot8 !== 61'd0) begin errors++; $display("FAIL reset_dot8: got %0d expected 0", dot8); end
    endtask

    task automatic test_single_tap();
        fe_t exp;
        chi_m[0] = 61'd1; chi_m[1] = 61'd0; chi_m[2] = 61'd0; chi_m[3] = 61'd0;
        v_m[0] = 61'd7; v_m[1] = 61'd9; v_m[2] = 61'd11; v_m[3] = 61'd13;
        exp = model_dot(4);
        pass2(0, 1'b0);
        checks++; if (dot2 !== exp) begin errors++; $display("FAIL single_tap_dot: got %0d expected %0d", dot2, exp); end
        checks++; if (rises2 !== 1) begin errors++; $display("FAIL single_tap_ready_rises: got %0d expected 1", rises2); end
        checks++; if (beats2 !== 4 || tmo2) begin errors++; $display("FAIL single_tap_beats: got %0d (timeout %0b) expected 4", beats2, tmo2); end
        checks++; if (restart_err2) begin errors++; $display("FAIL single_tap_held_en_restart: got restart expected none"); end
    endtask

    task automatic test_sums();
        fe_t exp;
        for (int i = 0; i < 4; i++) begin chi_m[i] = 61'd1; v_m[i] = fe_t'(i + 1); end
        exp = model_dot(4);
        pass2(20, 1'b0);
        checks++; if (dot2 !== exp) begin errors++; $display("FAIL sum_ones_dot: got %0d expected %0d", dot2, exp); end
        for (int i = 0; i < 4; i++) chi_m[i] = 61'd0;
        exp = model_dot(4);
        pass2(20, 1'b0);
        checks++; if (dot2 !== exp) begin errors++; $display("FAIL sum_zeros_dot: got %0d expected %0d", dot2, exp); end
    endtask

    task automatic test_wrap();
        fe_t exp;
        chi_m[0] = F_Q - 61'd1; chi_m[1] = 61'd1; chi_m[2] = 61'd0; chi_m[3] = 61'd0;
        v_m[0] = 61'd5; v_m[1] = 61'd5; v_m[2] = 61'd3; v_m[3] = 61'd3;
        exp = model_dot(4);
        pass2(0, 1'b0);
        checks++; if (dot2 !== exp) begin errors++; $display("FAIL wrap_cancel_dot: got %0d expected %0d", dot2, exp); end
        for (int i = 0; i < 4; i++) begin chi_m[i] = F_Q - 61'd1; v_m[i] = F_Q - 61'd1; end
        exp = model_dot(4);
        pass2(0, 1'b0);
        checks++; if (dot2 !== exp) begin errors++; $display("FAIL wrap_max_dot: got %0d expected %0d", dot2, exp); end
    endtask

    task automatic test_gaps();
        fe_t exp;
        chi_m[0] = 61'd1; chi_m[1] = 61'd0; chi_m[2] = 61'd0; chi_m[3] = 61'd0;
        v_m[0] = 61'd7; v_m[1] = 61'd9; v_m[2] = 61'd11; v_m[3] = 61'd13;
        exp = model_dot(4);
        pass2(60, 1'b0);
        checks++; if (dot2 !== exp) begin errors++; $display("FAIL gaps_dot: got %0d expected %0d", dot2, exp); end
        checks++; if (beats2 !== 4 || tmo2) begin errors++; $display("FAIL gaps_beats: got %0d (timeout %0b) expected 4", beats2, tmo2); end
        checks++; if (vr_err2) begin errors++; $display("FAIL gaps_val_ready_after_accept: got 1 expected 0"); end
    endtask

    task automatic test_reset_mid_pass();
        fe_t exp;
        int  cyc, beats;
        bit  hs;
        for (int i = 0; i < 4; i++) begin chi_m[i] = rand_fe(); v_m[i] = rand_fe(); chi2[i] = chi_m[i]; end
        @(negedge clk);
        en2 = 1'b1;
        beats = 0; cyc = 0;
        while (beats < 2 && cyc < 200) begin
            val_valid2 = 1'b1;
            val_in2    = v_m[beats];
            hs = val_ready2;
            @(negedge clk);
            cyc++;
            if (hs) beats++;
        end
        val_valid2 = 1'b0;
        checks++; if (beats !== 2) begin errors++; $display("FAIL midreset_reach_beat2: got %0d beats expected 2", beats); end
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        en2  = 1'b0;
        checks++; if (dot2 !== 61'd0) begin errors++; $display("FAIL midreset_dot: got %0d expected 0", dot2); end
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %0b expected 1", ready2); end
        checks++; if (val_ready2 !== 1'b0) begin errors++; $display("FAIL midreset_val_ready: got %0b expected 0", val_ready2); end
        for (int i = 0; i < 4; i++) begin chi_m[i] = rand_fe(); v_m[i] = rand_fe(); end
        exp = model_dot(4);
        pass2(30, 1'b1);
        checks++; if (dot2 !== exp) begin errors++; $display("FAIL midreset_restart_dot: got %0d expected %0d", dot2, exp); end
        checks++; if (beats2 !== 4 || rises2 !== 1) begin errors++; $display("FAIL midreset_busy_edge_ignored: got beats %0d rises %0d expected 4 and 1", beats2, rises2); end
    endtask

    task automatic test_back_to_back();
        fe_t exp;
        int  cyc, beats;
        bit  hs;
        for (int p = 0; p < 50; p++) begin
            for (int i = 0; i < 256; i++) begin chi_m[i] = rand_fe(); v_m[i] = rand_fe(); chi8[i] = chi_m[i]; end
            exp = model_dot(256);
            @(negedge clk);
            en8 = 1'b1;
            @(negedge clk);
            en8 = 1'b0;
            beats = 0; cyc = 0;
            while (!ready8 && cyc < 4000) begin
                val_valid8 = (beats < 256) && ($urandom_range(9) != 0);
                val_in8    = v_m[(beats < 256) ? beats : 0];
                hs = val_valid8 && val_ready8;
                @(negedge clk);
                cyc++;
                if (hs) beats++;
            end
            val_valid8 = 1'b0;
            checks++; if (dot8 !== exp) begin errors++; $display("FAIL b2b_dot pass %0d: got %0d expected %0d", p, dot8, exp); end
            checks++; if (beats !== 256 || cyc >= 4000) begin errors++; $display("FAIL b2b_beats pass %0d: got %0d beats in %0d cycles expected 256", p, beats, cyc); end
        end
    endtask

    initial begin
        rstb = 1'b1;
        en2 = 1'b0; val_valid2 = 1'b0; val_in2 = 61'd0; chi2 = '0;
        en8 = 1'b0; val_valid8 = 1'b0; val_in8 = 61'd0; chi8 = '0;
        test_reset();
        test_single_tap();
        test_sums();
        test_wrap();
        test_gaps();
        test_reset_mid_pass();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout: simulation still running at time %0t", $time);
        $fatal(1, "global timeout");
    end
endmodule
